ctrl_store_sequencer: RTL and testbench

//  Next-generation decode block for the pipelined core. Holds a writable control store indexed by opcode.

---
 rtl/ctrl_pkg.sv | 30 +++
 rtl/ctrl_store_ram.sv | 39 +++
 rtl/ctrl_store_sequencer.sv | 130 +++++++++++++
 tb/tb_ctrl_store_sequencer.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared definitions for the control-store sequencer: control-word field
// positions, the NOP field pattern and the sequencer state encoding.
package ctrl_pkg;

    localparam int CW_WB         = 0;
    localparam int CW_MEM_WRITE  = 1;
    localparam int CW_MEM_READ   = 2;
    localparam int CW_TYPEXTEND  = 3;
    localparam int CW_WR         = 4;
    localparam int CW_SEL_INPUT2 = 5;
    localparam int CW_SEL_DEST   = 6;
    localparam int CW_PCNOP      = 7;
    localparam int CW_J          = 8;
    localparam int CW_JR         = 9;
    localparam int CW_CALL       = 10;
    localparam int CW_ALUOP_LO   = 11;
    localparam int CW_ALUOP_HI   = 13;
    localparam int CW_PSEL_LO    = 14;
    localparam int CW_PSEL_HI    = 15;
    localparam int CW_REP_LO     = 16;
    localparam int CW_FIELDS_W   = 16;

    localparam logic [CW_FIELDS_W-1:0] CW_NOP_FIELDS = '0;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_REPEAT = 1'b1
    } seq_state_e;

endpackage

// File: rtl/ctrl_store_ram.sv
// Writable control store: async read, sync write, with a loaded[] bitmap and
// write-through bypass so a same-cycle load is visible to the reader.
module ctrl_store_ram #(
    parameter int OPC_W = 5,
    parameter int CW_W  = 18
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_we,
    input  logic [OPC_W-1:0] i_waddr,
    input  logic [CW_W-1:0]  i_wdata,
    input  logic [OPC_W-1:0] i_raddr,
    output logic [CW_W-1:0]  o_rdata,
    output logic             o_rloaded
);
    localparam int DEPTH = 2**OPC_W;

    logic [CW_W-1:0]  r_mem [DEPTH];
    logic [DEPTH-1:0] r_loaded;
    logic             w_hit;

    // Contents are intentionally not reset; only the loaded bitmap is.
    always_ff @(posedge clk) begin
        if (i_we)
            r_mem[i_waddr] <= i_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_loaded <= '0;
        else if (i_we)
            r_loaded[i_waddr] <= 1'b1;
    end

    assign w_hit     = i_we && (i_waddr == i_raddr);
    assign o_rdata   = w_hit ? i_wdata : r_mem[i_raddr];
    assign o_rloaded = w_hit | r_loaded[i_raddr];

endmodule

// File: rtl/ctrl_store_sequencer.sv
// Decode stage: looks up the opcode in the control store, registers the word into
// ID/EX and replays it REP extra cycles for multi-cycle instructions.
module ctrl_store_sequencer
    import ctrl_pkg::*;
#(
    parameter  int OPC_W = 5,
    parameter  int REP_W = 2,
    localparam int CW_W  = 16 + REP_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_en,
    input  logic [OPC_W-1:0] load_addr,
    input  logic [CW_W-1:0]  load_data,
    input  logic [OPC_W-1:0] opcode,
    input  logic             opcode_valid,
    input  logic             stall,
    input  logic             flush,
    output logic             ready,
    output logic             ctrl_valid,
    output logic             illegal,
    output logic [REP_W-1:0] uop_idx,
    output logic [CW_W-1:0]  ctrl_word,
    output logic             WB,
    output logic             MEM_Write,
    output logic             MEM_Read,
    output logic             typextend,
    output logic             WR,
    output logic             Sel_input2,
    output logic             Sel_Dest,
    output logic             PCNop,
    output logic             J,
    output logic             JR,
    output logic             CALL,
    output logic [2:0]       Aluop,
    output logic [1:0]       Psel
);
    localparam logic [CW_W-1:0] NOP_WORD = {{REP_W{1'b0}}, CW_NOP_FIELDS};

    seq_state_e       r_state;
    logic [REP_W-1:0] r_rem;
    logic [REP_W-1:0] r_idx;
    logic [CW_W-1:0]  r_word;
    logic             r_valid;
    logic             r_illegal;

    logic [CW_W-1:0]  w_rdata;
    logic             w_rloaded;
    logic [CW_W-1:0]  w_issue_word;
    logic [REP_W-1:0] w_issue_rep;

    ctrl_store_ram #(.OPC_W(OPC_W), .CW_W(CW_W)) u_ram (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_we      (load_en),
        .i_waddr   (load_addr),
        .i_wdata   (load_data),
        .i_raddr   (opcode),
        .o_rdata   (w_rdata),
        .o_rloaded (w_rloaded)
    );

    // An unloaded opcode decodes to NOP, whose REP field of 0 makes it single-cycle.
    assign w_issue_word = w_rloaded ? w_rdata : NOP_WORD;
    assign w_issue_rep  = w_issue_word[CW_W-1:CW_REP_LO];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_idx     <= '0;
            r_word    <= NOP_WORD;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (flush) begin
            r_state   <= ST_IDLE;
            r_rem     <= '0;
            r_idx     <= '0;
            r_word    <= NOP_WORD;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!stall) begin
            case (r_state)
                ST_REPEAT: begin
                    r_idx <= r_idx + REP_W'(1);
                    r_rem <= r_rem - REP_W'(1);
                    if (r_rem == REP_W'(1))
                        r_state <= ST_IDLE;
                end
                default: begin
                    if (opcode_valid) begin
                        r_word    <= w_issue_word;
                        r_illegal <= ~w_rloaded;
                        r_valid   <= 1'b1;
                        r_idx     <= '0;
                        r_rem     <= w_issue_rep;
                        if (w_issue_rep != '0)
                            r_state <= ST_REPEAT;
                    end else begin
                        r_word    <= NOP_WORD;
                        r_illegal <= 1'b0;
                        r_valid   <= 1'b0;
                        r_idx     <= '0;
                    end
                end
            endcase
        end
    end

    assign ready      = (r_state == ST_IDLE) && !stall;
    assign ctrl_valid = r_valid;
    assign illegal    = r_illegal;
    assign uop_idx    = r_idx;
    assign ctrl_word  = r_word;

    assign WB         = r_word[CW_WB];
    assign MEM_Write  = r_word[CW_MEM_WRITE];
    assign MEM_Read   = r_word[CW_MEM_READ];
    assign typextend  = r_word[CW_TYPEXTEND];
    assign WR         = r_word[CW_WR];
    assign Sel_input2 = r_word[CW_SEL_INPUT2];
    assign Sel_Dest   = r_word[CW_SEL_DEST];
    assign PCNop      = r_word[CW_PCNOP];
    assign J          = r_word[CW_J];
    assign JR         = r_word[CW_JR];
    assign CALL       = r_word[CW_CALL];
    assign Aluop      = r_word[CW_ALUOP_HI:CW_ALUOP_LO];
    assign Psel       = r_word[CW_PSEL_HI:CW_PSEL_LO];

endmodule

// File: tb/tb_ctrl_store_sequencer.sv
// Bench for ctrl_store_sequencer: directed vector table, hand-written reset/flush
// sequences, then random traffic against a behavioural model.
module tb_ctrl_store_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load_en, opcode_valid, stall, flush;
    logic [4:0]  load_addr, opcode;
    logic [17:0] load_data;
    logic        ready, ctrl_valid, illegal;
    logic [1:0]  uop_idx;
    logic [17:0] ctrl_word;
    logic        WB, MEM_Write, MEM_Read, typextend, WR, Sel_input2, Sel_Dest, PCNop, J, JR, CALL;
    logic [2:0]  Aluop;
    logic [1:0]  Psel;

    always #5 clk = ~clk;

    ctrl_store_sequencer #(.OPC_W(5), .REP_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr), .load_data(load_data),
        .opcode(opcode), .opcode_valid(opcode_valid), .stall(stall), .flush(flush),
        .ready(ready), .ctrl_valid(ctrl_valid), .illegal(illegal), .uop_idx(uop_idx),
        .ctrl_word(ctrl_word), .WB(WB), .MEM_Write(MEM_Write), .MEM_Read(MEM_Read),
        .typextend(typextend), .WR(WR), .Sel_input2(Sel_input2), .Sel_Dest(Sel_Dest),
        .PCNop(PCNop), .J(J), .JR(JR), .CALL(CALL), .Aluop(Aluop), .Psel(Psel)
    );

    typedef struct {
        logic        le;
        logic [4:0]  la;
        logic [17:0] ld;
        logic [4:0]  op;
        logic        ov, st, fl;
        logic        rdy, vld, ill;
        logic [1:0]  idx;
        logic [17:0] word;
    } vec_t;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    // Behavioural model: store contents, loaded flags, visible micro-op and
    // how many further micro-ops the current instruction still owes.
    logic [17:0] m_mem [32];
    bit          m_loaded [32];
    bit          m_vld, m_ill;
    int          m_idx, m_rem;
    logic [17:0] m_word;

    function automatic vec_t mk(input logic le, input logic [4:0] la, input logic [17:0] ld,
                                input logic [4:0] op, input logic ov, input logic st, input logic fl,
                                input logic rdy, input logic vld, input logic ill,
                                input logic [1:0] idx, input logic [17:0] word);
        vec_t v;
        v.le = le; v.la = la; v.ld = ld; v.op = op; v.ov = ov; v.st = st; v.fl = fl;
        v.rdy = rdy; v.vld = vld; v.ill = ill; v.idx = idx; v.word = word;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_loaded[i] = 1'b0;
        m_vld = 0; m_ill = 0; m_idx = 0; m_rem = 0; m_word = '0;
    endtask

    task automatic model_edge(input vec_t v);
        bit          hit, lded;
        logic [17:0] w;
        hit = v.le && (v.la == v.op);
        if (v.fl) begin
            m_vld = 0; m_ill = 0; m_idx = 0; m_rem = 0; m_word = '0;
        end else if (v.st) begin
            // everything holds
        end else if (m_rem > 0) begin
            m_idx = m_idx + 1;
            m_rem = m_rem - 1;
        end else if (v.ov) begin
            lded   = m_loaded[v.op] || hit;
            w      = hit ? v.ld : (lded ? m_mem[v.op] : 18'h0);
            m_vld  = 1; m_ill = !lded; m_idx = 0; m_word = w;
            m_rem  = int'(w[17:16]);
        end else begin
            m_vld = 0; m_ill = 0; m_idx = 0; m_word = '0;
        end
        if (v.le) begin
            m_mem[v.la]    = v.ld;
            m_loaded[v.la] = 1'b1;
        end
    endtask

    task automatic check_outs(input string tag, input bit e_vld, input bit e_ill,
                              input int e_idx, input logic [17:0] e_word);
        logic [15:0] fields;
        fields = {Psel, Aluop, CALL, JR, J, PCNop, Sel_Dest, Sel_input2, WR, typextend,
                  MEM_Read, MEM_Write, WB};
        chk({tag, " ctrl_valid"}, 32'(ctrl_valid), 32'(e_vld));
        chk({tag, " illegal"},    32'(illegal),    32'(e_ill));
        chk({tag, " uop_idx"},    32'(uop_idx),    32'(e_idx));
        chk({tag, " ctrl_word"},  32'(ctrl_word),  32'(e_word));
        chk({tag, " fields"},     32'(fields),     32'(e_word[15:0]));
    endtask

    task automatic drive(input vec_t v);
        load_en = v.le; load_addr = v.la; load_data = v.ld;
        opcode = v.op; opcode_valid = v.ov; stall = v.st; flush = v.fl;
    endtask

    // One clock: drive, check combinational ready, clock, check registered outputs.
    task automatic step(input vec_t v, input bit use_tbl, input string tag);
        bit e_rdy;
        drive(v);
        #1;
        e_rdy = use_tbl ? v.rdy : (m_rem == 0 && !v.st);
        chk({tag, " ready"}, 32'(ready), 32'(e_rdy));
        @(posedge clk);
        model_edge(v);
        #1;
        if (use_tbl) check_outs(tag, v.vld, v.ill, int'(v.idx), v.word);
        else         check_outs(tag, m_vld, m_ill, m_idx, m_word);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t idle, v;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(idle);
        model_reset();
        #12;
        chk("reset ready", 32'(ready), 32'd1);
        check_outs("reset", 0, 0, 0, 18'h0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        //          le la     ld         op     ov st fl  rdy vld ill idx word
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h03, 1, 0, 0,  1, 1, 1, 0, 18'h0));
        tbl.push_back(mk(1, 5'h01, 18'h00811, 5'h00, 0, 0, 0,  1, 0, 0, 0, 18'h0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 0, 0,  1, 1, 0, 0, 18'h00811));
        tbl.push_back(mk(1, 5'h07, 18'h20123, 5'h00, 0, 0, 0,  1, 0, 0, 0, 18'h0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h07, 1, 0, 0,  1, 1, 0, 0, 18'h20123));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 0, 0,  0, 1, 0, 1, 18'h20123));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 0, 0,  0, 1, 0, 2, 18'h20123));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 0, 0,  1, 1, 0, 0, 18'h00811));
        tbl.push_back(mk(1, 5'h0C, 18'h3A5F0, 5'h00, 0, 0, 0,  1, 0, 0, 0, 18'h0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h0C, 1, 0, 0,  1, 1, 0, 0, 18'h3A5F0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 0, 0,  0, 1, 0, 1, 18'h3A5F0));
        tbl.push_back(mk(1, 5'h0C, 18'h00001, 5'h00, 0, 1, 0,  0, 1, 0, 1, 18'h3A5F0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 1, 0,  0, 1, 0, 1, 18'h3A5F0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 0, 0,  0, 1, 0, 2, 18'h3A5F0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 0, 0,  0, 1, 0, 3, 18'h3A5F0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 0, 0,  1, 0, 0, 0, 18'h0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h0C, 1, 0, 0,  1, 1, 0, 0, 18'h00001));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h07, 1, 0, 0,  1, 1, 0, 0, 18'h20123));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h00, 0, 0, 0,  0, 1, 0, 1, 18'h20123));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 1, 1,  0, 0, 0, 0, 18'h0));
        tbl.push_back(mk(0, 5'h00, 18'h0,     5'h01, 1, 0, 0,  1, 1, 0, 0, 18'h00811));
        tbl.push_back(mk(1, 5'h0A, 18'h1C0C3, 5'h0A, 1, 0, 0,  1, 1, 0, 0, 18'h1C0C3));

        for (int i = 0; i < tbl.size(); i++)
            step(tbl[i], 1'b1, $sformatf("tbl%0d", i));

        // Async reset in the middle of the REP=1 sequence just issued.
        drive(idle);
        #1;
        chk("midrep ready", 32'(ready), 32'd0);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async reset ready", 32'(ready), 32'd1);
        check_outs("async reset", 0, 0, 0, 18'h0);
        model_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Loaded bitmap cleared: 5'h0A is illegal again.
        step(mk(0, 0, 0, 5'h0A, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "post-reset 0A");
        chk("post-reset 0A illegal", 32'(illegal), 32'd1);
        // Load under stall, then a flush drops the presented opcode.
        step(mk(1, 5'h01, 18'h1F0F0, 5'h01, 1, 1, 0, 0, 0, 0, 0, 0), 1'b0, "stall load");
        step(mk(0, 0, 0, 5'h01, 1, 0, 1, 0, 0, 0, 0, 0), 1'b0, "flush drop");
        chk("flush drop valid", 32'(ctrl_valid), 32'd0);
        step(mk(0, 0, 0, 5'h01, 1, 0, 0, 0, 0, 0, 0, 0), 1'b0, "issue after stall load");
        chk("stall load word", 32'(ctrl_word), 32'h1F0F0);

        for (int n = 0; n < 3000; n++) begin
            v.le = ($urandom_range(0, 3) == 0);
            v.la = 5'($urandom_range(0, 7));
            v.ld = 18'($urandom);
            v.op = 5'($urandom_range(0, 7));
            v.ov = ($urandom_range(0, 3) != 0);
            v.st = ($urandom_range(0, 4) == 0);
            v.fl = ($urandom_range(0, 9) == 0);
            v.rdy = 0; v.vld = 0; v.ill = 0; v.idx = 0; v.word = 0;
            step(v, 1'b0, $sformatf("rnd%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
